regfile_wb_sched: RTL and testbench

Write-back scheduler and load scoreboard in front of the 32x32 register file (one write port, x0 hard-wired to zero).
- Arbitrates the single write port between the ALU write-back path and the load/store unit (LSU) return path, using round-robin valid/ready handshakes.
- Tracks registers with outstanding loads and issues a stall to the decode stage on RAW/WAW hazards.
- Sits between the execute/LSU stages and the register file; drives its write_enable, rd_address and rd_data.

---
 rtl/regfile_wb_sched.sv | 135 +++++++++++++
 tb/tb_regfile_wb_sched.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler and load scoreboard for a 32x32 register file with a single write port.
// Round-robin arbitration between ALU and LSU returns; outstanding loads stall decode on RAW/WAW hazards.
module regfile_wb_sched #(
    parameter int MAX_LOADS = 4,
    parameter int CNT_WIDTH = $clog2(MAX_LOADS + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [4:0]           alu_rd,
    input  logic [31:0]          alu_data,
    input  logic                 lsu_valid,
    output logic                 lsu_ready,
    input  logic [4:0]           lsu_rd,
    input  logic [31:0]          lsu_data,
    input  logic                 issue_valid,
    input  logic                 issue_load,
    input  logic [4:0]           issue_rs1,
    input  logic [4:0]           issue_rs2,
    input  logic [4:0]           issue_rd,
    output logic                 stall,
    output logic                 write_enable,
    output logic [4:0]           rd_address,
    output logic [31:0]          rd_data,
    output logic [31:0]          busy,
    output logic                 error
);

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } src_e;

    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_LOADS);
    localparam logic [CNT_WIDTH-1:0] ONE_CNT = CNT_WIDTH'(1);

    src_e                 rr_last_r;
    logic [CNT_WIDTH-1:0] cnt_r;
    logic [CNT_WIDTH-1:0] cnt_nxt_s;
    logic [31:0]          busy_r;
    logic [31:0]          busy_nxt_s;
    logic [31:0]          set_mask_s;
    logic [31:0]          clr_mask_s;
    logic                 error_r;
    logic                 error_nxt_s;
    logic                 we_r;
    logic [4:0]           addr_r;
    logic [31:0]          data_r;
    logic                 alu_ready_s;
    logic                 lsu_ready_s;
    logic                 alu_hs_s;
    logic                 lsu_hs_s;
    logic                 stall_s;
    logic                 load_acc_s;

    // Grant, hazard detection and next-state for the scoreboard
    always_comb begin
        // A side is ready unless the other side is requesting and it is the other side's turn
        alu_ready_s = !lsu_valid || (rr_last_r == SRC_LSU);
        lsu_ready_s = !alu_valid || (rr_last_r == SRC_ALU);
        alu_hs_s    = alu_valid && alu_ready_s;
        lsu_hs_s    = lsu_valid && lsu_ready_s;

        stall_s = issue_valid && (busy_r[issue_rs1] || busy_r[issue_rs2] || busy_r[issue_rd] ||
                                  (issue_load && (cnt_r == MAX_CNT)));
        load_acc_s = issue_valid && issue_load && !stall_s;

        set_mask_s = load_acc_s ? (32'd1 << issue_rd) : 32'd0;
        clr_mask_s = lsu_hs_s   ? (32'd1 << lsu_rd)   : 32'd0;
        busy_nxt_s = ((busy_r & ~clr_mask_s) | set_mask_s) & ~32'd1;

        case ({load_acc_s, lsu_hs_s})
            2'b10:   cnt_nxt_s = cnt_r + ONE_CNT;
            2'b01:   cnt_nxt_s = (cnt_r == {CNT_WIDTH{1'b0}}) ? {CNT_WIDTH{1'b0}} : (cnt_r - ONE_CNT);
            default: cnt_nxt_s = cnt_r;
        endcase

        error_nxt_s = error_r ||
                      (lsu_hs_s && (((lsu_rd != 5'd0) && !busy_r[lsu_rd]) ||
                                    (cnt_r == {CNT_WIDTH{1'b0}})));
    end

    // Arbitration history, scoreboard and sticky error state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_last_r <= SRC_ALU;
            cnt_r     <= {CNT_WIDTH{1'b0}};
            busy_r    <= 32'd0;
            error_r   <= 1'b0;
        end else begin
            if (alu_hs_s) begin
                rr_last_r <= SRC_ALU;
            end else if (lsu_hs_s) begin
                rr_last_r <= SRC_LSU;
            end else begin
                rr_last_r <= rr_last_r;
            end
            cnt_r   <= cnt_nxt_s;
            busy_r  <= busy_nxt_s;
            error_r <= error_nxt_s;
        end
    end

    // Register-file write port; address and data hold between writes
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            we_r   <= 1'b0;
            addr_r <= 5'd0;
            data_r <= 32'd0;
        end else if (alu_hs_s) begin
            we_r   <= (alu_rd != 5'd0);
            addr_r <= alu_rd;
            data_r <= alu_data;
        end else if (lsu_hs_s) begin
            we_r   <= (lsu_rd != 5'd0);
            addr_r <= lsu_rd;
            data_r <= lsu_data;
        end else begin
            we_r   <= 1'b0;
            addr_r <= addr_r;
            data_r <= data_r;
        end
    end

    assign alu_ready    = alu_ready_s;
    assign lsu_ready    = lsu_ready_s;
    assign stall        = stall_s;
    assign write_enable = we_r;
    assign rd_address   = addr_r;
    assign rd_data      = data_r;
    assign busy         = busy_r;
    assign error        = error_r;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed self-checking bench for regfile_wb_sched: arbitration, write path, scoreboard and error flag.
module tb_regfile_wb_sched;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        alu_valid = 1'b0;
    logic        alu_ready;
    logic [4:0]  alu_rd = 5'd0;
    logic [31:0] alu_data = 32'd0;
    logic        lsu_valid = 1'b0;
    logic        lsu_ready;
    logic [4:0]  lsu_rd = 5'd0;
    logic [31:0] lsu_data = 32'd0;
    logic        issue_valid = 1'b0;
    logic        issue_load = 1'b0;
    logic [4:0]  issue_rs1 = 5'd0;
    logic [4:0]  issue_rs2 = 5'd0;
    logic [4:0]  issue_rd = 5'd0;
    logic        stall;
    logic        write_enable;
    logic [4:0]  rd_address;
    logic [31:0] rd_data;
    logic [31:0] busy;
    logic        error;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_wb_sched #(.MAX_LOADS(4)) dut (
        .clock(clock), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .issue_valid(issue_valid), .issue_load(issue_load), .issue_rs1(issue_rs1),
        .issue_rs2(issue_rs2), .issue_rd(issue_rd), .stall(stall),
        .write_enable(write_enable), .rd_address(rd_address), .rd_data(rd_data),
        .busy(busy), .error(error)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic issue(input logic v, input logic ld, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd);
        issue_valid = v; issue_load = ld; issue_rs1 = rs1; issue_rs2 = rs2; issue_rd = rd;
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if (write_enable !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", write_enable); end
        n_checks++; if (rd_address !== 5'd0) begin n_fail++; $display("FAIL reset_addr got %0d want 0", rd_address); end
        n_checks++; if (rd_data !== 32'd0) begin n_fail++; $display("FAIL reset_data got %h want 0", rd_data); end
        n_checks++; if (busy !== 32'd0) begin n_fail++; $display("FAIL reset_busy got %h want 0", busy); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error got %b want 0", error); end
        n_checks++; if ({alu_ready, lsu_ready} !== 2'b11) begin n_fail++; $display("FAIL reset_ready got %b want 11", {alu_ready, lsu_ready}); end
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic test_alu_write();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        #1;
        n_checks++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL alu_ready got %b want 1", alu_ready); end
        tick();
        alu_valid = 1'b0;
        n_checks++; if ({write_enable, rd_address, rd_data} !== {1'b1, 5'd5, 32'hDEADBEEF})
            begin n_fail++; $display("FAIL alu_write got we=%b addr=%0d data=%h want 1/5/deadbeef", write_enable, rd_address, rd_data); end
        tick();
        n_checks++; if ({write_enable, rd_address} !== {1'b0, 5'd5})
            begin n_fail++; $display("FAIL alu_write_hold got we=%b addr=%0d want 0/5", write_enable, rd_address); end
    endtask

    task automatic test_round_robin();
        do_reset();
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hA0;
        lsu_valid = 1'b1; lsu_rd = 5'd8; lsu_data = 32'hB0;
        for (int i = 0; i < 4; i++) begin
            logic lsu_turn;
            lsu_turn = (i % 2 == 0);
            #1;
            n_checks++; if ({alu_ready, lsu_ready} !== {!lsu_turn, lsu_turn})
                begin n_fail++; $display("FAIL rr_ready[%0d] got alu=%b lsu=%b want lsu=%b", i, alu_ready, lsu_ready, lsu_turn); end
            tick();
            n_checks++; if ({write_enable, rd_address} !== {1'b1, (lsu_turn ? 5'd8 : 5'd7)})
                begin n_fail++; $display("FAIL rr_write[%0d] got we=%b addr=%0d", i, write_enable, rd_address); end
        end
        alu_valid = 1'b0; lsu_valid = 1'b0;
        do_reset();
    endtask

    task automatic test_load_hazard();
        issue(1'b1, 1'b1, 5'd0, 5'd0, 5'd3);
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL hz_load_stall got %b want 0", stall); end
        tick();
        issue(1'b1, 1'b0, 5'd3, 5'd0, 5'd10);
        #1;
        n_checks++; if (busy !== 32'h8) begin n_fail++; $display("FAIL hz_busy got %h want 8", busy); end
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL hz_stall[%0d] got %b want 1", i, stall); end
            tick();
        end
        lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h33;
        #1;
        n_checks++; if ({lsu_ready, stall} !== 2'b11) begin n_fail++; $display("FAIL hz_ret got ready=%b stall=%b want 1/1", lsu_ready, stall); end
        tick();
        lsu_valid = 1'b0;
        n_checks++; if ({stall, busy, error} !== {1'b0, 32'd0, 1'b0})
            begin n_fail++; $display("FAIL hz_clear got stall=%b busy=%h err=%b", stall, busy, error); end
        n_checks++; if ({write_enable, rd_address, rd_data} !== {1'b1, 5'd3, 32'h33})
            begin n_fail++; $display("FAIL hz_write got we=%b addr=%0d data=%h", write_enable, rd_address, rd_data); end
        issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        tick();
    endtask

    task automatic test_max_loads();
        logic [4:0] ret [4] = '{5'd2, 5'd3, 5'd4, 5'd6};
        for (int r = 1; r <= 4; r++) begin
            issue(1'b1, 1'b1, 5'd0, 5'd0, 5'(r));
            #1;
            n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL max_ld[%0d] stall got %b want 0", r, stall); end
            tick();
        end
        issue(1'b1, 1'b1, 5'd0, 5'd0, 5'd6);
        #1;
        n_checks++; if ({stall, busy} !== {1'b1, 32'h1E}) begin n_fail++; $display("FAIL max_full got stall=%b busy=%h want 1/1e", stall, busy); end
        tick();
        lsu_valid = 1'b1; lsu_rd = 5'd1;
        #1;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL max_hold got %b want 1", stall); end
        tick();
        lsu_valid = 1'b0;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL max_release got %b want 0", stall); end
        tick();
        issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        n_checks++; if (busy !== 32'h5C) begin n_fail++; $display("FAIL max_busy got %h want 5c", busy); end
        for (int i = 0; i < 4; i++) begin
            lsu_valid = 1'b1; lsu_rd = ret[i];
            tick();
        end
        lsu_valid = 1'b0;
        n_checks++; if ({busy, error} !== {32'd0, 1'b0}) begin n_fail++; $display("FAIL max_drain got busy=%h err=%b", busy, error); end
    endtask

    task automatic test_error();
        lsu_valid = 1'b1; lsu_rd = 5'd9;
        tick();
        lsu_valid = 1'b0;
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL err_set got %b want 1", error); end
        alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'h11;
        tick(); tick();
        alu_valid = 1'b0;
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b want 1", error); end
        do_reset();
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL err_reset got %b want 0", error); end
        lsu_valid = 1'b1; lsu_rd = 5'd0;
        tick();
        lsu_valid = 1'b0;
        n_checks++; if ({error, write_enable, busy} !== {1'b1, 1'b0, 32'd0})
            begin n_fail++; $display("FAIL err_underflow got err=%b we=%b busy=%h", error, write_enable, busy); end
        do_reset();
    endtask

    task automatic test_alu_rd0();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
        #1;
        n_checks++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL rd0_ready got %b want 1", alu_ready); end
        tick();
        alu_valid = 1'b0;
        n_checks++; if ({write_enable, busy} !== {1'b0, 32'd0}) begin n_fail++; $display("FAIL rd0_we got we=%b busy=%h", write_enable, busy); end
    endtask

    task automatic test_reset_mid();
        issue(1'b1, 1'b1, 5'd0, 5'd0, 5'd3);
        tick();
        issue(1'b1, 1'b1, 5'd0, 5'd0, 5'd4);
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
        tick();
        issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        alu_valid = 1'b0;
        n_checks++; if ({busy, write_enable} !== {32'h18, 1'b1}) begin n_fail++; $display("FAIL mid_pre got busy=%h we=%b", busy, write_enable); end
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if ({write_enable, rd_address, rd_data, busy, error} !== {1'b0, 5'd0, 32'd0, 32'd0, 1'b0})
            begin n_fail++; $display("FAIL mid_reset got we=%b addr=%0d data=%h busy=%h err=%b", write_enable, rd_address, rd_data, busy, error); end
        alu_valid = 1'b1; lsu_valid = 1'b1;
        #1;
        n_checks++; if ({alu_ready, lsu_ready} !== 2'b01) begin n_fail++; $display("FAIL mid_rr got %b want 01", {alu_ready, lsu_ready}); end
        alu_valid = 1'b0; lsu_valid = 1'b0;
        tick();
        reset = 1'b0;
        for (int r = 1; r <= 4; r++) begin
            issue(1'b1, 1'b1, 5'd0, 5'd0, 5'(r));
            #1;
            n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mid_cnt[%0d] stall got %b want 0", r, stall); end
            tick();
        end
        issue(1'b1, 1'b1, 5'd0, 5'd0, 5'd6);
        #1;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL mid_full stall got %b want 1", stall); end
        issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        do_reset();
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_round_robin();
        test_load_hazard();
        test_max_loads();
        test_error();
        test_alu_rd0();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
